// File: rtl/dstack_spill_if.sv
// Memory-side bus of the stack spill/fill engine.
// The engine is the master: it raises mem_req with mem_we/mem_addr/mem_wdata
// and holds them until the memory answers with mem_ack. Read data on
// mem_rdata is valid in the same cycle as mem_ack.
//   mem_req   master->slave  request pending
//   mem_we    master->slave  1 = write (spill), 0 = read (fill)
//   mem_addr  master->slave  word address
//   mem_wdata master->slave  write data
//   mem_ack   slave->master  request complete
//   mem_rdata slave->master  read data
interface dstack_spill_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic                  mem_ack;
  logic [WIDTH-1:0]      mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dstack_spill.sv
// Spill/fill engine backing a fixed-depth on-chip data stack with memory.
// Tracks on-chip occupancy from the core's stack movements, writes the
// deepest entry out when the stack runs high and reads the most recently
// spilled entry back under the bottom when it runs low.
// Ports:
//   clk, reset    clock, asynchronous active-low reset
//   movement      00 none, 01 push, 10 pop once, 11 pop twice
//   stall         combinational: core must not apply movement this cycle
//   onchip_depth  valid on-chip entries
//   spill_count   entries held in memory (memory stack pointer)
//   bottom_val    deepest valid on-chip entry, from the stack
//   drop_bottom   pulse: stack discards its deepest entry
//   fill_valid    pulse: stack inserts fill_val below its deepest entry
//   fill_val      value to insert
//   underflow     sticky: a pop asked for more entries than exist anywhere
//   mem_full      sticky: a spill was needed but memory stack is full
//   mem           memory request/acknowledge bus (master side)
module dstack_spill #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_MAG  = 7,
  parameter int DEPTH      = 65,
  parameter int HIGH_MARK  = 56,
  parameter int LOW_MARK   = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            movement,
  output logic                  stall,
  output logic [DEPTH_MAG-1:0]  onchip_depth,
  output logic [ADDR_WIDTH-1:0] spill_count,
  input  logic [WIDTH-1:0]      bottom_val,
  output logic                  drop_bottom,
  output logic                  fill_valid,
  output logic [WIDTH-1:0]      fill_val,
  output logic                  underflow,
  output logic                  mem_full,
  dstack_spill_if.master        mem
);

  typedef enum logic [1:0] {IDLE, SPILL, FILL, FILLED} state_t;

  localparam logic [DEPTH_MAG-1:0]  DEPTH_V   = DEPTH_MAG'(DEPTH);
  localparam logic [DEPTH_MAG-1:0]  DEPTH_M1  = DEPTH_MAG'(DEPTH - 1);
  localparam logic [DEPTH_MAG-1:0]  HIGH_V    = DEPTH_MAG'(HIGH_MARK);
  localparam logic [DEPTH_MAG-1:0]  LOW_V     = DEPTH_MAG'(LOW_MARK);
  localparam logic [DEPTH_MAG-1:0]  ONE_D     = DEPTH_MAG'(1);
  localparam logic [DEPTH_MAG-1:0]  TWO_D     = DEPTH_MAG'(2);
  localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] SPILL_MAX = '1;
  localparam int                    EXT       = ADDR_WIDTH + 1 - DEPTH_MAG;

  state_t                state, state_next;
  logic                  push;
  logic [DEPTH_MAG-1:0]  pop_n;
  logic [ADDR_WIDTH:0]   occ_total;
  logic                  underflow_hit;
  logic [DEPTH_MAG-1:0]  depth_next;
  logic [ADDR_WIDTH-1:0] spill_next;
  logic                  req_next, we_next, mem_full_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [WIDTH-1:0]      wdata_next, fill_val_next;

  // Decode the core's movement and decide whether it must be held off.
  // While a spill is in flight at least one entry must survive the pops so
  // that drop_bottom still has something to remove; while a fill is in
  // flight one slot is kept free for the entry arriving in FILLED.
  always_comb begin
    push          = 1'b0;
    pop_n         = '0;
    stall         = 1'b0;
    underflow_hit = 1'b0;
    occ_total     = {{EXT{1'b0}}, onchip_depth} + {1'b0, spill_count};
    unique case (movement)
      2'b01:   push  = 1'b1;
      2'b10:   pop_n = ONE_D;
      2'b11:   pop_n = TWO_D;
      default: ;
    endcase
    if (push && onchip_depth == DEPTH_V)
      stall = 1'b1;
    if (pop_n != '0 && onchip_depth < pop_n)
      stall = 1'b1;
    if (state == SPILL && pop_n != '0 && onchip_depth < pop_n + TWO_D)
      stall = 1'b1;
    if (state == FILL && push && onchip_depth >= DEPTH_M1)
      stall = 1'b1;
    if (pop_n != '0 && occ_total < {{EXT{1'b0}}, pop_n})
      underflow_hit = 1'b1;
  end

  // Next-state and registered-output logic of the spill/fill controller.
  // Request fields are latched on leaving IDLE and simply held until ack;
  // drop_bottom is asserted in the ack cycle itself so the depth update
  // sees it together with any movement in that same cycle.
  always_comb begin
    state_next    = state;
    req_next      = mem.mem_req;
    we_next       = mem.mem_we;
    addr_next     = mem.mem_addr;
    wdata_next    = mem.mem_wdata;
    fill_val_next = fill_val;
    spill_next    = spill_count;
    mem_full_next = mem_full;
    drop_bottom   = 1'b0;
    fill_valid    = 1'b0;
    unique case (state)
      IDLE: begin
        if (onchip_depth > HIGH_V) begin
          if (spill_count == SPILL_MAX) begin
            mem_full_next = 1'b1;
          end else begin
            state_next = SPILL;
            req_next   = 1'b1;
            we_next    = 1'b1;
            addr_next  = spill_count;
            wdata_next = bottom_val;
          end
        end else if (onchip_depth < LOW_V && spill_count != '0) begin
          state_next = FILL;
          req_next   = 1'b1;
          we_next    = 1'b0;
          addr_next  = spill_count - ONE_A;
        end
      end
      SPILL: begin
        if (mem.mem_ack) begin
          drop_bottom = 1'b1;
          spill_next  = spill_count + ONE_A;
          req_next    = 1'b0;
          state_next  = IDLE;
        end
      end
      FILL: begin
        if (mem.mem_ack) begin
          fill_val_next = mem.mem_rdata;
          spill_next    = spill_count - ONE_A;
          req_next      = 1'b0;
          state_next    = FILLED;
        end
      end
      FILLED: begin
        fill_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Occupancy update: accepted movement, a spilled entry leaving the bottom
  // and a filled entry arriving under it all apply in the same cycle.
  always_comb begin
    depth_next = onchip_depth;
    if (!stall) begin
      if (push)
        depth_next = depth_next + ONE_D;
      depth_next = depth_next - pop_n;
    end
    if (drop_bottom)
      depth_next = depth_next - ONE_D;
    if (fill_valid)
      depth_next = depth_next + ONE_D;
  end

  // State and register update; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      onchip_depth  <= '0;
      spill_count   <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      fill_val      <= '0;
      underflow     <= 1'b0;
      mem_full      <= 1'b0;
    end else begin
      state         <= state_next;
      onchip_depth  <= depth_next;
      spill_count   <= spill_next;
      mem.mem_req   <= req_next;
      mem.mem_we    <= we_next;
      mem.mem_addr  <= addr_next;
      mem.mem_wdata <= wdata_next;
      fill_val      <= fill_val_next;
      underflow     <= underflow | underflow_hit;
      mem_full      <= mem_full_next;
    end
  end

endmodule
